// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core instruction sequencer.
// Holds the FSM state encoding, the core's 34-bit instruction bit map and the
// all-idle instruction word that is driven whenever nothing is in flight.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_RD,
        S_W_LOAD,
        S_GAP,
        S_X_RD,
        S_EXEC,
        S_DRAIN,
        S_NEXT,
        S_FIN
    } state_t;

    localparam int INST_W          = 34;
    localparam int ADDR_W          = 11;

    localparam int INST_ACC        = 33;
    localparam int INST_CEN_PMEM   = 32;
    localparam int INST_WEN_PMEM   = 31;
    localparam int INST_A_PMEM_LSB = 20;
    localparam int INST_CEN_XMEM   = 19;
    localparam int INST_WEN_XMEM   = 18;
    localparam int INST_A_XMEM_LSB = 7;
    localparam int INST_OFIFO_RD   = 6;
    localparam int INST_IFIFO_WR   = 5;
    localparam int INST_IFIFO_RD   = 4;
    localparam int INST_L0_RD      = 3;
    localparam int INST_L0_WR      = 2;
    localparam int INST_EXECUTE    = 1;
    localparam int INST_LOAD       = 0;

    // Both memories deselected and in read mode, every strobe low.
    localparam logic [INST_W-1:0] IDLE_WORD =
        (34'd1 << INST_CEN_PMEM) | (34'd1 << INST_WEN_PMEM) |
        (34'd1 << INST_CEN_XMEM) | (34'd1 << INST_WEN_XMEM);

    function automatic int cmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_ctrl_phase_cnt.sv
// Loadable down-counter with terminal-count flag. One instance times every
// fixed-length phase of the sequencer; it is reloaded on each phase entry.
module core_ctrl_phase_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/core_inst_sequencer.sv
// Hardware initiator for the core's 34-bit instruction bus.
// Per kernel position: weights xmem->L0->PEs, activations xmem->L0, execute,
// then drain the OFIFO into the SFU with accumulate. inst is registered, so the
// word for a state appears one cycle after the state is entered.
// Build option: CTRL_PMEM_WB_EN makes each drain pop also write pmem at
// kij*LEN_ONIJ + pop_index; without it pmem stays deselected at address 0.
module core_inst_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int          ROW      = 8,
    parameter int          COL      = 8,
    parameter int          LEN_NIJ  = 36,
    parameter int          LEN_ONIJ = 16,
    parameter int          LEN_KIJ  = 9,
    parameter logic [10:0] W_BASE   = 11'h400,
    parameter logic [10:0] X_BASE   = 11'h000,
    parameter int          IDLE_GAP = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic [3:0]  kij,
    output logic        busy,
    output logic        done
);

    localparam int N_WRD = COL + 1;
    localparam int N_WLD = ROW + COL;
    localparam int N_GAP = IDLE_GAP + 1;
    localparam int N_XRD = LEN_NIJ + 1;
    localparam int N_EXE = ROW + COL + LEN_NIJ;
    localparam int N_MAX = cmax(cmax(cmax(N_WRD, N_WLD), cmax(N_GAP, N_XRD)), N_EXE);
    localparam int CW    = $clog2(N_MAX);
    localparam int PW    = $clog2(LEN_ONIJ + 1);

    localparam logic [CW-1:0] LD_WRD = CW'(N_WRD - 1);
    localparam logic [CW-1:0] LD_WLD = CW'(N_WLD - 1);
    localparam logic [CW-1:0] LD_GAP = CW'(N_GAP - 1);
    localparam logic [CW-1:0] LD_XRD = CW'(N_XRD - 1);
    localparam logic [CW-1:0] LD_EXE = CW'(N_EXE - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_ld;
    logic                w_dec;
    logic [CW-1:0]       w_ld_val;
    logic [CW-1:0]       w_cnt;
    logic                w_tc;
    logic [CW-1:0]       w_idx;
    logic [PW-1:0]       r_pops;
    logic                w_pop;
    logic [INST_W-1:0]   w_word;
    logic [INST_W-1:0]   r_inst;
    logic [3:0]          r_kij;
    logic                r_busy;
    logic                r_done;

    core_ctrl_phase_cnt #(.W(CW)) u_phase_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    // A pop is only issued when the previous word did not pop: the valid we see
    // cannot yet reflect a pop still sitting in the output register.
    assign w_pop = (r_state == S_DRAIN) && ofifo_valid &&
                   !r_inst[INST_OFIFO_RD] && (r_pops < PW'(LEN_ONIJ));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state, phase-counter control and the instruction word for this state.
    always_comb begin
        w_next   = r_state;
        w_ld     = 1'b0;
        w_ld_val = '0;
        w_dec    = 1'b0;
        w_idx    = '0;
        w_word   = IDLE_WORD;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_W_RD;
                    w_ld     = 1'b1;
                    w_ld_val = LD_WRD;
                end
            end
            S_W_RD: begin
                // Word 0 only issues the first read; later words capture the
                // previous read into L0, address holding on the last one.
                w_idx = LD_WRD - w_cnt;
                w_word[INST_CEN_XMEM] = 1'b0;
                w_word[INST_A_XMEM_LSB +: ADDR_W] = W_BASE +
                    ((w_idx > CW'(COL - 1)) ? ADDR_W'(COL - 1) : ADDR_W'(w_idx));
                w_word[INST_L0_WR] = (w_idx != '0);
                if (w_tc) begin
                    w_next   = S_W_LOAD;
                    w_ld     = 1'b1;
                    w_ld_val = LD_WLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_W_LOAD: begin
                w_word[INST_LOAD]  = 1'b1;
                w_word[INST_L0_RD] = 1'b1;
                if (w_tc) begin
                    w_next   = S_GAP;
                    w_ld     = 1'b1;
                    w_ld_val = LD_GAP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_GAP: begin
                if (w_tc) begin
                    w_next   = S_X_RD;
                    w_ld     = 1'b1;
                    w_ld_val = LD_XRD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_X_RD: begin
                // Final word only writes L0, so xmem is deselected there.
                w_idx = LD_XRD - w_cnt;
                w_word[INST_CEN_XMEM] = (w_idx == LD_XRD);
                w_word[INST_A_XMEM_LSB +: ADDR_W] = X_BASE +
                    ((w_idx > CW'(LEN_NIJ - 1)) ? ADDR_W'(LEN_NIJ - 1) : ADDR_W'(w_idx));
                w_word[INST_L0_WR] = (w_idx != '0);
                if (w_tc) begin
                    w_next   = S_EXEC;
                    w_ld     = 1'b1;
                    w_ld_val = LD_EXE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_EXEC: begin
                w_word[INST_EXECUTE] = 1'b1;
                w_word[INST_L0_RD]   = 1'b1;
                if (w_tc)
                    w_next = S_DRAIN;
                else
                    w_dec = 1'b1;
            end
            S_DRAIN: begin
                if (w_pop) begin
                    w_word[INST_OFIFO_RD] = 1'b1;
                    w_word[INST_ACC]      = 1'b1;
`ifdef CTRL_PMEM_WB_EN
                    w_word[INST_CEN_PMEM] = 1'b0;
                    w_word[INST_WEN_PMEM] = 1'b0;
                    w_word[INST_A_PMEM_LSB +: ADDR_W] =
                        ADDR_W'(int'(r_kij) * LEN_ONIJ + int'(r_pops));
`endif
                end
                if (r_pops == PW'(LEN_ONIJ))
                    w_next = S_NEXT;
            end
            S_NEXT: begin
                if (r_kij == 4'(LEN_KIJ - 1)) begin
                    w_next = S_FIN;
                end else begin
                    w_next   = S_W_RD;
                    w_ld     = 1'b1;
                    w_ld_val = LD_WRD;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output word, kernel index, pop count and run handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst <= IDLE_WORD;
            r_kij  <= '0;
            r_pops <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_inst <= w_word;
            r_done <= (r_state == S_FIN);
            if (r_state == S_IDLE && start) begin
                r_kij  <= '0;
                r_busy <= 1'b1;
            end else if (r_state == S_NEXT && r_kij != 4'(LEN_KIJ - 1)) begin
                r_kij <= r_kij + 4'd1;
            end
            if (r_state == S_FIN)
                r_busy <= 1'b0;
            if (r_state != S_DRAIN)
                r_pops <= '0;
            else if (w_pop)
                r_pops <= r_pops + 1'b1;
        end
    end

    assign inst = r_inst;
    assign kij  = r_kij;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: reset/abort, exact per-phase word
// sequences, drain pacing with ofifo_valid held and interrupted, full 9-kij run.
module tb_core_inst_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic [3:0]  kij;
    logic        busy;
    logic        done;

    int total    = 0;
    int passes   = 0;
    int fails    = 0;
    int done_cnt = 0;

    localparam logic [33:0] IW = 34'h1_800C_0000;
    localparam logic [33:0] WL = IW | 34'h9;
    localparam logic [33:0] EX = IW | 34'hA;

    core_inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .kij         (kij),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    function automatic logic [33:0] w_rd_word(input int i);
        logic [33:0] e;
        e        = IW;
        e[19]    = 1'b0;
        e[17:7]  = 11'h400 + 11'((i > 7) ? 7 : i);
        e[2]     = (i != 0);
        return e;
    endfunction

    function automatic logic [33:0] x_rd_word(input int i);
        logic [33:0] e;
        e        = IW;
        e[19]    = (i == 36);
        e[17:7]  = 11'((i > 35) ? 35 : i);
        e[2]     = (i != 0);
        return e;
    endfunction

    function automatic logic [33:0] pop_word(input int k, input int p);
        logic [33:0] e;
        e     = IW;
        e[33] = 1'b1;
        e[6]  = 1'b1;
`ifdef CTRL_PMEM_WB_EN
        e[32]    = 1'b0;
        e[31]    = 1'b0;
        e[30:20] = 11'(k * 16 + p);
`endif
        return e;
    endfunction

    task automatic phases(input int k, input int n_exec);
        for (int i = 0; i < 9; i++) begin
            step(); chk("w_rd", inst, w_rd_word(i));
            if (i == 0) begin chk("kij", kij, k); chk("busy_run", busy, 1); end
        end
        for (int i = 0; i < 16; i++) begin step(); chk("w_load", inst, WL); end
        for (int i = 0; i < 11; i++) begin step(); chk("gap", inst, IW); end
        for (int i = 0; i < 37; i++) begin step(); chk("x_rd", inst, x_rd_word(i)); end
        for (int i = 0; i < n_exec; i++) begin step(); chk("exec", inst, EX); end
    endtask

    task automatic drain(input int k, input int low_after);
        int pops    = 0;
        bit prev    = 0;
        bit lowered = 0;
        for (int c = 0; c < 200 && pops < 16; c++) begin
            step();
            chk("acc_eq_rd", inst[33], inst[6]);
            chk("no_back2back", prev & inst[6], 0);
            if (low_after < 0) chk("alt_pop", inst[6], (c % 2 == 0));
            if (inst[6]) begin
                chk("pop_word", inst, pop_word(k, pops));
`ifdef CTRL_PMEM_WB_EN
                if (k == 2 && pops == 5) begin
                    chk("pmem_k2_p5_addr", inst[30:20], 37);
                    chk("pmem_k2_p5_en", inst[32:31], 0);
                end
`endif
                pops++;
            end else begin
                chk("drain_idle", inst, IW);
            end
            prev = inst[6];
            if (low_after >= 0 && !lowered && pops == low_after) begin
                lowered     = 1;
                ofifo_valid = 1'b0;
                for (int j = 0; j < 20; j++) begin step(); chk("held_low", inst[6], 0); end
                prev        = 0;
                ofifo_valid = 1'b1;
            end
        end
        chk("pop_total", pops, 16);
    endtask

    task automatic tail(input int k);
        step(); chk("drain_exit", inst, IW);
        step(); chk("next_word", inst, IW); chk("done_early", done, 0);
        if (k == 8) begin
            step();
            chk("fin_word", inst, IW);
            chk("done_pulse", done, 1);
            chk("busy_clr", busy, 0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", inst, IW);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kij", kij, 0);
        reset = 1'b0;
        step(); chk("idle_hold", inst, IW);

        // First run, aborted by reset part-way through kij 1 EXEC.
        start = 1'b1;
        step(); chk("start_busy", busy, 1); chk("start_word", inst, IW);
        start = 1'b0;
        phases(0, 52);
        drain(0, -1);
        tail(0);
        phases(1, 10);
        #2 reset = 1'b1;
        #1;
        chk("abort_inst", inst, IW);
        chk("abort_busy", busy, 0);
        chk("abort_kij", kij, 0);
        step(); chk("abort_hold", inst, IW);
        reset = 1'b0;
        step(); chk("post_abort_idle", inst, IW); chk("post_abort_busy", busy, 0);

        // Full run; start held through kij 3, ofifo_valid dropped in kij 1 drain.
        done_cnt = 0;
        start = 1'b1;
        step(); chk("start2_busy", busy, 1);
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 3) start = 1'b1;
            phases(k, 52);
            start = 1'b0;
            drain(k, (k == 1) ? 6 : -1);
            tail(k);
        end
        step();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_word", inst, IW);
        chk("done_count", done_cnt, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
